vga_window_addr_gen: RTL and testbench

- Parametrised successor to the fixed-window frame-buffer address counter.
- Converts the VGA timing generator's column/row counts into a linear frame-buffer read address for pixels inside a configurable active window.
- Adds runtime integer upscaling (1x/2x/4x pixel and line replication), line/frame strobes, and resync on vertical blanking.
- Sits between the VGA timing counters and the SRAM/frame-buffer read port.

---
 rtl/vga_window_addr_gen.sv | 119 +++++++++++
 tb/tb_vga_window_addr_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_window_addr_gen.sv
// vga_window_addr_gen: VGA col/row to frame-buffer address with 1x/2x/4x upscaling.
// Optional VGA_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module vga_window_addr_gen #(
  parameter int COL_W    = 10,
  parameter int ADDR_W   = 20,
  parameter int H_START  = 160,
  parameter int V_START  = 45,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pix_en,
  input  logic [COL_W-1:0]  colcnt,
  input  logic [COL_W-1:0]  rowcnt,
  input  logic [1:0]        scale,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              line_done,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);
  localparam int CW = COL_W + 1;
  localparam logic [CW-1:0] H_LO   = CW'(H_START);
  localparam logic [CW-1:0] H_HI   = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] H_LAST = CW'(H_START + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LO   = CW'(V_START);
  localparam logic [CW-1:0] V_HI   = CW'(V_START + V_ACTIVE);
  localparam logic [CW-1:0] V_LAST = CW'(V_START + V_ACTIVE - 1);
  if (64'(H_ACTIVE) * 64'(V_ACTIVE) > (64'd1 << ADDR_W)) begin : g_addr_chk
    $error("vga_window_addr_gen: H_ACTIVE*V_ACTIVE does not fit ADDR_W");
  end
  if ((H_ACTIVE % 4) != 0 || (V_ACTIVE % 4) != 0) begin : g_div_chk
    $error("vga_window_addr_gen: H_ACTIVE and V_ACTIVE must be divisible by 4");
  end
  logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d;
  logic [COL_W-1:0]  x_idx_q, x_idx_d;
  logic [1:0]        x_rep_q, x_rep_d, y_rep_q, y_rep_d, scale_q, scale_d, rep_max;
  logic              addr_valid_q, addr_valid_d, line_done_q, line_done_d, frame_done_q, frame_done_d;
  logic [CW-1:0]     col_x, row_x;
  logic              s, in_win, blank;
  assign col_x   = {1'b0, colcnt};
  assign row_x   = {1'b0, rowcnt};
  assign s       = enable & pix_en;
  assign blank   = row_x < V_LO;
  assign in_win  = (col_x >= H_LO) & (col_x < H_HI) & (row_x >= V_LO) & (row_x < V_HI);
  assign rep_max = (scale_q == 2'd2) ? 2'd3 : (scale_q == 2'd1) ? 2'd1 : 2'd0;
  always_comb begin
    addr_d       = addr_q;
    line_base_d  = line_base_q;
    x_idx_d      = x_idx_q;
    x_rep_d      = x_rep_q;
    y_rep_d      = y_rep_q;
    scale_d      = scale_q;
    addr_valid_d = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    if (s && blank) begin
      line_base_d = '0;
      x_idx_d     = '0;
      x_rep_d     = '0;
      y_rep_d     = '0;
      scale_d     = (scale == 2'd3) ? 2'd0 : scale;
    end else if (s && in_win) begin
      addr_valid_d = 1'b1;
      addr_d       = line_base_q + ADDR_W'(x_idx_q);
      x_rep_d      = (x_rep_q == rep_max) ? 2'd0 : x_rep_q + 2'd1;
      x_idx_d      = (x_rep_q == rep_max) ? x_idx_q + COL_W'(1) : x_idx_q;
      if (col_x == H_LAST) begin
        line_done_d  = 1'b1;
        frame_done_d = row_x == V_LAST;
        x_rep_d      = '0;
        x_idx_d      = '0;
        y_rep_d      = (row_x == V_LAST || y_rep_q == rep_max) ? 2'd0 : y_rep_q + 2'd1;
        line_base_d  = (row_x == V_LAST) ? '0 :
                       (y_rep_q == rep_max) ? line_base_q + ADDR_W'(H_ACTIVE >> scale_q) : line_base_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      line_base_q  <= '0;
      x_idx_q      <= '0;
      x_rep_q      <= '0;
      y_rep_q      <= '0;
      scale_q      <= '0;
      addr_valid_q <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      line_base_q  <= line_base_d;
      x_idx_q      <= x_idx_d;
      x_rep_q      <= x_rep_d;
      y_rep_q      <= y_rep_d;
      scale_q      <= scale_d;
      addr_valid_q <= addr_valid_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  always_comb frame_cnt_d = frame_done_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_d;
  end
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_window_addr_gen.sv
// tb_vga_window_addr_gen: randomized scan of vga_window_addr_gen against a sample-count reference model.
module tb_vga_window_addr_gen;
  localparam int H0 = 160, V0 = 45, HA = 640, VA = 480, HL = 799, VL = 524;
`ifdef VGA_FRAME_CNT_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, enable, pix_en;
  logic [9:0] colcnt, rowcnt;
  logic [1:0] scale;
  logic [19:0] addr;
  logic addr_valid, line_done, frame_done;
  logic [15:0] frame_cnt;
  int total = 0, bad = 0;
  int m_pix, m_lines, m_sc, m_frames, e_addr, e_fcnt;
  logic e_valid, e_ld, e_fd;
  int snap[int];

  vga_window_addr_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_en(pix_en), .colcnt(colcnt), .rowcnt(rowcnt),
    .scale(scale), .addr(addr), .addr_valid(addr_valid), .line_done(line_done),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a pixel's source column is (in-window samples earlier in the line)/rep and
  // its source line is (lines completed this frame)/rep, with rep = 2^scale.
  task automatic px(input int c, input int r, input bit en, input bit pe, input int sc);
    int rep;
    colcnt = 10'(c); rowcnt = 10'(r); enable = en; pix_en = pe; scale = 2'(sc);
    e_valid = 1'b0; e_ld = 1'b0; e_fd = 1'b0;
    e_fcnt = FC ? m_frames % 65536 : 0;
    if (en && pe) begin
      if (r < V0) begin
        m_pix = 0; m_lines = 0; m_sc = (sc == 3) ? 0 : sc;
      end else if (r < V0 + VA && c >= H0 && c < H0 + HA) begin
        rep = 1 << m_sc;
        e_valid = 1'b1;
        e_addr = (m_lines / rep) * (HA / rep) + m_pix / rep;
        m_pix++;
        if (c == HL) begin
          e_ld = 1'b1; m_pix = 0; m_lines++;
          if (r == VL) begin e_fd = 1'b1; m_lines = 0; end
        end
      end
    end
    if (e_fd) m_frames++;
    @(posedge clk); #1;
    if (addr_valid) snap[c * 1024 + r] = int'(addr);
  endtask

  task automatic scan_row(input int r, input int c0, input int c1, input int sc, input bit noise);
    int c = c0;
    int k;
    while (c <= c1) begin
      if (noise && $urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, 2));
        if (k == 0) px(c, r, 1'b0, 1'b1, sc);
        else if (k == 1) px(c, r, 1'b1, 1'b0, sc);
        else px(int'($urandom_range(0, 159)), r, 1'b1, 1'b1, sc);
      end else begin
        px(c, r, 1'b1, 1'b1, sc);
        c++;
      end
      total++;
      if (addr_valid !== e_valid || line_done !== e_ld || frame_done !== e_fd ||
          frame_cnt !== 16'(e_fcnt) || (e_valid && addr !== 20'(e_addr))) begin
        bad++;
        $display("FAIL scan (%0d,%0d): got v=%b a=%0d ld=%b fd=%b fc=%0d want v=%b a=%0d ld=%b fd=%b fc=%0d",
                 colcnt, rowcnt, addr_valid, addr, line_done, frame_done, frame_cnt,
                 e_valid, e_addr, e_ld, e_fd, e_fcnt);
      end
    end
  endtask

  task automatic frame(input int sc_early, input int sc_late);
    snap.delete();
    scan_row(10, 0, 0, sc_early, 1'b0);
    for (int r = V0; r <= VL; r++) begin
      if (r <= V0 + 4 || r == VL) scan_row(r, H0, HL, r < 100 ? sc_early : sc_late, 1'b1);
      else begin
        scan_row(r, H0, H0, r < 100 ? sc_early : sc_late, 1'b0);
        scan_row(r, HL, HL, r < 100 ? sc_early : sc_late, 1'b1);
      end
    end
  endtask

  function automatic int sv(input int c, input int r);
    return snap.exists(c * 1024 + r) ? snap[c * 1024 + r] : -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; pix_en = 1'b0; colcnt = '0; rowcnt = '0; scale = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_pix = 0; m_lines = 0; m_sc = 0; m_frames = 0;
    total++;
    if (addr !== 20'd0 || addr_valid !== 1'b0 || line_done !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset: got a=%0d v=%b ld=%b fd=%b fc=%0d want all 0", addr, addr_valid, line_done, frame_done, frame_cnt);
    end
  endtask

  task automatic test_frames_1x;
    for (int f = 0; f < 3; f++) begin
      frame(0, 0);
      total++;
      if (sv(160, 45) != 0 || sv(799, 45) != 639 || sv(160, 46) != 640 || sv(799, 524) != 307199) begin
        bad++;
        $display("FAIL frame1x: got %0d %0d %0d %0d want 0 639 640 307199",
                 sv(160, 45), sv(799, 45), sv(160, 46), sv(799, 524));
      end
    end
    px(300, 600, 1'b1, 1'b1, 0);
    total++;
    if (frame_cnt !== (FC ? 16'd3 : 16'd0) || addr_valid !== 1'b0) begin
      bad++;
      $display("FAIL frame_cnt: got %0d v=%b want %0d v=0", frame_cnt, addr_valid, FC ? 3 : 0);
    end
  endtask

  task automatic test_scale2x;
    frame(1, 1);
    total++;
    if (sv(160, 45) != 0 || sv(161, 45) != 0 || sv(162, 45) != 1 || sv(799, 45) != 319 ||
        sv(160, 46) != 0 || sv(160, 47) != 320 || sv(799, 524) != 76799) begin
      bad++;
      $display("FAIL scale2x: got %0d %0d %0d %0d %0d %0d %0d want 0 0 1 319 0 320 76799",
               sv(160, 45), sv(161, 45), sv(162, 45), sv(799, 45), sv(160, 46), sv(160, 47), sv(799, 524));
    end
  endtask

  task automatic test_scale_change;
    frame(0, 2);
    total++;
    if (sv(799, 524) != 307199 || sv(160, 200) != 99200) begin
      bad++;
      $display("FAIL scale_change: got %0d %0d want 307199 99200", sv(799, 524), sv(160, 200));
    end
    frame(2, 2);
    total++;
    if (sv(163, 45) != 0 || sv(164, 45) != 1 || sv(160, 49) != 160 || sv(799, 524) != 19199) begin
      bad++;
      $display("FAIL scale4x: got %0d %0d %0d %0d want 0 1 160 19199",
               sv(163, 45), sv(164, 45), sv(160, 49), sv(799, 524));
    end
  endtask

  task automatic test_enable_gap;
    scan_row(5, 0, 0, 0, 1'b0);
    for (int r = V0; r < 50; r++) scan_row(r, HL, HL, 0, 1'b0);
    scan_row(50, H0, 300, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      px(300, 50, 1'b0, 1'b1, 0);
      total++;
      if (addr_valid !== 1'b0 || line_done !== 1'b0) begin
        bad++;
        $display("FAIL enable_gap: got v=%b ld=%b want 0 0", addr_valid, line_done);
      end
    end
    px(301, 50, 1'b1, 1'b1, 0);
    total++;
    if (addr_valid !== 1'b1 || addr !== 20'd3341) begin
      bad++;
      $display("FAIL enable_resume: got v=%b a=%0d want v=1 a=3341", addr_valid, addr);
    end
  endtask

  task automatic test_reset_mid;
    scan_row(5, 0, 0, 1, 1'b0);
    for (int r = V0; r < 200; r++) scan_row(r, HL, HL, 1, 1'b0);
    scan_row(200, H0, 399, 1, 1'b1);
    rst = 1'b1;
    px(400, 200, 1'b1, 1'b1, 1);
    rst = 1'b0;
    m_pix = 0; m_lines = 0; m_sc = 0; m_frames = 0;
    total++;
    if (addr !== 20'd0 || addr_valid !== 1'b0 || line_done !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid: got a=%0d v=%b ld=%b fd=%b fc=%0d want all 0", addr, addr_valid, line_done, frame_done, frame_cnt);
    end
    scan_row(200, 100, 100, 0, 1'b0);
    scan_row(200, 401, 405, 0, 1'b0);
    scan_row(3, 0, 0, 0, 1'b0);
    snap.delete();
    scan_row(V0, H0, H0, 0, 1'b0);
    total++;
    if (sv(160, 45) != 0) begin
      bad++;
      $display("FAIL reset_resync: got %0d want 0", sv(160, 45));
    end
  endtask

  task automatic test_random;
    int r, c;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 44)) : int'($urandom_range(45, 540));
      c = ($urandom_range(0, 3) == 0) ? HL : int'($urandom_range(0, 1023));
      px(c, r, $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0, int'($urandom_range(0, 3)));
      total++;
      if (addr_valid !== e_valid || line_done !== e_ld || frame_done !== e_fd ||
          frame_cnt !== 16'(e_fcnt) || (e_valid && addr !== 20'(e_addr))) begin
        bad++;
        $display("FAIL random (%0d,%0d): got v=%b a=%0d ld=%b fd=%b want v=%b a=%0d ld=%b fd=%b",
                 c, r, addr_valid, addr, line_done, frame_done, e_valid, e_addr, e_ld, e_fd);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frames_1x;
    test_scale2x;
    test_scale_change;
    test_enable_gap;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
